// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word/opcode types plus the ALU arbiter state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  // Fixed encodings kept so older tooling can match raw state values.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    HOLD = ST_HOLD
  } aluarb_state_t;

  localparam int ALUARB_MAXREQ = 4;

endpackage

// File: rtl/alu_if.sv
// alu_if: connection to the shared ALU; the arbiter drives op/a/b through the tb modport.
interface alu_if;
  import cpu_types_pkg::*;

  aluop_t     op;
  word_t      a;
  word_t      b;
  word_t      out;
  logic [2:0] flags;

  modport tb  (output op, a, b, input out, flags);
  modport dut (input op, a, b, output out, flags);

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            enable,
  output logic [NREQ-1:0] gnt
);

  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   gnt_rot;
  logic [2*NREQ-1:0] gnt_dbl;

  // Rotate so ptr sits at bit 0, keep the lowest set bit, then rotate back.
  always_comb begin
    req_rot = NREQ'({req, req} >> ptr);
    gnt_rot = req_rot & (~req_rot + NREQ'(1));
    gnt_dbl = {{NREQ{1'b0}}, gnt_rot} << ptr;
    if (enable) begin
      gnt = gnt_dbl[NREQ-1:0] | gnt_dbl[2*NREQ-1:NREQ];
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU among NREQ requesters with held responses.
// Define ALU_ARB_STATS_EN to add the stat_gnt/stat_stall counter outputs.
module alu_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0][3:0]        req_op,
  input  logic [NREQ-1:0][31:0]       req_a,
  input  logic [NREQ-1:0][31:0]       req_b,
  output logic [NREQ-1:0]             gnt,
  output logic [NREQ-1:0]             rsp_valid,
  input  logic [NREQ-1:0]             rsp_ready,
  output logic [31:0]                 rsp_out,
  output logic [2:0]                  rsp_flags,
`ifdef ALU_ARB_STATS_EN
  output logic [NREQ-1:0][CNT_W-1:0]  stat_gnt,
  output logic [CNT_W-1:0]            stat_stall,
`else
`endif
  alu_if.tb                           aluif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  aluarb_state_t state;
  aluarb_state_t state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] owner;
  logic [PW-1:0] winner;
  logic          grant_en;
  logic          accept;
  aluop_t        op_q;
  word_t         a_q;
  word_t         b_q;

  // A new operand set may only enter when the ALU slot is free or being vacated now.
  assign grant_en = !RST && ((state == IDLE) || ((state == HOLD) && rsp_ready[owner]));
  assign accept   = |gnt;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req    (req),
    .ptr    (ptr),
    .enable (grant_en),
    .gnt    (gnt)
  );

  assign aluif.op = op_q;
  assign aluif.a  = a_q;
  assign aluif.b  = b_q;

  // Encode the one-hot grant and advance the pointer past the winner.
  always_comb begin
    winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        winner = PW'(i);
      end else begin
        winner = winner;
      end
    end
    if (winner == PW'(NREQ - 1)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = winner + PW'(1);
    end
  end

  // Next-state logic; an accept in HOLD implies the owner's ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
      EXEC: state_nxt = HOLD;
      HOLD: begin
        if (accept) begin
          state_nxt = EXEC;
        end else if (rsp_ready[owner]) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = HOLD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer, operand latch and result capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      op_q      <= ALU_ADD;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rsp_out   <= 32'd0;
      rsp_flags <= 3'd0;
      rsp_valid <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ptr   <= ptr_nxt;
        owner <= winner;
        op_q  <= aluop_t'(req_op[winner]);
        a_q   <= req_a[winner];
        b_q   <= req_b[winner];
      end
      if (state == EXEC) begin
        rsp_out   <= aluif.out;
        rsp_flags <= aluif.flags;
      end
      // Owner is stable on every path into HOLD, so this matches the next state.
      rsp_valid <= (state_nxt == HOLD) ? (NREQ'(1) << owner) : '0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Per-requester accept counts and cycles where requests waited unserved.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_gnt   <= '0;
      stat_stall <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          stat_gnt[i] <= stat_gnt[i] + CNT_W'(1);
        end
      end
      if ((|req) && !(|gnt)) begin
        stat_stall <= stat_stall + CNT_W'(1);
      end
    end
  end
`else
  // CNT_W only sizes the statistics counters, which are absent in this build.
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios with a response scoreboard and a bench-side ALU.
module tb_alu_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ  = 2;
  localparam int CNT_W = 32;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0][3:0]   req_op;
  logic [NREQ-1:0][31:0]  req_a;
  logic [NREQ-1:0][31:0]  req_b;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [31:0]            rsp_out;
  logic [2:0]             rsp_flags;
`ifdef ALU_ARB_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] stat_gnt;
  logic [CNT_W-1:0]           stat_stall;
`endif

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [NREQ-1:0] vld;
    logic [31:0]     out;
    logic [2:0]      flags;
  } exp_t;

  exp_t sb[$];

  alu_if aluif ();

  alu_arbiter #(
    .NREQ  (NREQ),
    .CNT_W (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req       (req),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_flags (rsp_flags),
`ifdef ALU_ARB_STATS_EN
    .stat_gnt  (stat_gnt),
    .stat_stall(stat_stall),
`endif
    .aluif     (aluif)
  );

  always #5 CLK = ~CLK;

  // Reference ALU attached to the interface.
  word_t alu_res;
  logic  alu_ovf;
  always_comb begin
    alu_ovf = 1'b0;
    case (aluif.op)
      ALU_ADD: begin
        alu_res = aluif.a + aluif.b;
        alu_ovf = (aluif.a[31] == aluif.b[31]) && (alu_res[31] != aluif.a[31]);
      end
      ALU_SUB: begin
        alu_res = aluif.a - aluif.b;
        alu_ovf = (aluif.a[31] != aluif.b[31]) && (alu_res[31] != aluif.a[31]);
      end
      ALU_AND: alu_res = aluif.a & aluif.b;
      ALU_OR:  alu_res = aluif.a | aluif.b;
      ALU_XOR: alu_res = aluif.a ^ aluif.b;
      default: alu_res = 32'd0;
    endcase
  end
  assign aluif.out   = alu_res;
  assign aluif.flags = {alu_ovf, alu_res[31], (alu_res == 32'd0)};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int idx, input aluop_t op, input logic [31:0] a, input logic [31:0] b);
    req_op[idx] = op;
    req_a[idx]  = a;
    req_b[idx]  = b;
  endtask

  task automatic push(input logic [NREQ-1:0] vld, input logic [31:0] out, input logic [2:0] flags);
    exp_t e;
    e.vld   = vld;
    e.out   = out;
    e.flags = flags;
    sb.push_back(e);
  endtask

  // Monitor: compare each consumed response against the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if ((rsp_valid & rsp_ready) != '0) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: got rsp_valid=%b, required no response", rsp_valid);
        end else begin
          e = sb.pop_front();
          chk("mon_rsp_valid", 32'(rsp_valid), 32'(e.vld));
          chk("mon_rsp_out",   rsp_out,        e.out);
          chk("mon_rsp_flags", 32'(rsp_flags), 32'(e.flags));
        end
      end
    end
  end

  initial begin : stimulus
    RST = 1'b1; req = 2'b11; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;

    // Reset: no grant while RST high, then all registered outputs cleared.
    @(negedge CLK); #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    @(negedge CLK); RST = 1'b0; req = 2'b00; #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_out",   rsp_out,        32'h0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'h0);
    chk("rst_alu_op",    32'(aluif.op),  32'(ALU_ADD));
    chk("rst_alu_a",     aluif.a,        32'h0);
    chk("rst_alu_b",     aluif.b,        32'h0);

    // Single op; a request raised in EXEC and dropped before grant is lost.
    @(negedge CLK); drive(0, ALU_ADD, 32'd5, 32'd7); req = 2'b01; #1;
    chk("t1_gnt", 32'(gnt), 32'h1);
    push(2'b01, 32'd12, 3'b000);
    @(negedge CLK); req = 2'b10; drive(1, ALU_ADD, 32'h0000DEAD, 32'd1); #1;
    chk("t1_exec_gnt",   32'(gnt),       32'h0);
    chk("t1_exec_valid", 32'(rsp_valid), 32'h0);
    chk("t1_alu_op",     32'(aluif.op),  32'(ALU_ADD));
    chk("t1_alu_a",      aluif.a,        32'd5);
    chk("t1_alu_b",      aluif.b,        32'd7);
    @(negedge CLK); req = 2'b00; rsp_ready = 2'b01; #1;
    chk("t1_hold_valid", 32'(rsp_valid), 32'h1);
    chk("t1_hold_gnt",   32'(gnt),       32'h0);
    @(negedge CLK); rsp_ready = 2'b00; #1;
    chk("t1_idle_valid", 32'(rsp_valid), 32'h0);
    chk("t1_dropped_a",  aluif.a,        32'd5);

    // Contention from reset: three ops alternating fairly.
    @(negedge CLK); RST = 1'b1; #1;
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
    drive(0, ALU_OR, 32'h80000000, 32'h00000001);
    drive(1, ALU_XOR, 32'hF0F0F0F0, 32'hFFFFFFFF);
    req = 2'b11; #1;
    chk("t2_gnt0", 32'(gnt), 32'h1);
    push(2'b01, 32'h80000001, 3'b010);
    @(negedge CLK); req = 2'b10; #1;
    chk("t2_exec_gnt", 32'(gnt), 32'h0);
    @(negedge CLK); drive(0, ALU_AND, 32'hFFFF0000, 32'h0000FFFF); req = 2'b11; rsp_ready = 2'b01; #1;
    chk("t2_gnt1",   32'(gnt),       32'h2);
    chk("t2_valid0", 32'(rsp_valid), 32'h1);
    push(2'b10, 32'h0F0F0F0F, 3'b000);
    @(negedge CLK); req = 2'b01; rsp_ready = 2'b00; #1;
    chk("t2_exec2_gnt", 32'(gnt),      32'h0);
    chk("t2_alu_op",    32'(aluif.op), 32'(ALU_XOR));
    @(negedge CLK); rsp_ready = 2'b10; #1;
    chk("t2_gnt0_again", 32'(gnt),       32'h1);
    chk("t2_valid1",     32'(rsp_valid), 32'h2);
    push(2'b01, 32'h00000000, 3'b001);
    @(negedge CLK); req = 2'b00; rsp_ready = 2'b00;
    @(negedge CLK); rsp_ready = 2'b01; #1;
    chk("t2_valid0_again", 32'(rsp_valid), 32'h1);
    @(negedge CLK); rsp_ready = 2'b00; #1;
    chk("t2_idle_valid", 32'(rsp_valid), 32'h0);
`ifdef ALU_ARB_STATS_EN
    chk("t6_stat_gnt0", stat_gnt[0], 32'd2);
    chk("t6_stat_gnt1", stat_gnt[1], 32'd1);
    chk("t6_stat_stall", stat_stall, 32'd2);
`endif

    // Backpressure on a zero result, then back-to-back overflow add for req1.
    @(negedge CLK); drive(0, ALU_SUB, 32'd3, 32'd3); drive(1, ALU_ADD, 32'h7FFFFFFF, 32'd1); req = 2'b01; #1;
    chk("t3_gnt0", 32'(gnt), 32'h1);
    push(2'b01, 32'h00000000, 3'b001);
    @(negedge CLK); req = 2'b10; #1;
    chk("t3_exec_gnt", 32'(gnt), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); #1;
      chk("t3_bp_valid", 32'(rsp_valid), 32'h1);
      chk("t3_bp_gnt",   32'(gnt),       32'h0);
      chk("t3_bp_out",   rsp_out,        32'h0);
      chk("t3_bp_flags", 32'(rsp_flags), 32'h1);
    end
    @(negedge CLK); rsp_ready = 2'b01; #1;
    chk("t4_b2b_gnt", 32'(gnt), 32'h2);
    push(2'b10, 32'h80000000, 3'b110);
    @(negedge CLK); req = 2'b00; rsp_ready = 2'b00; #1;
    chk("t4_exec_valid", 32'(rsp_valid), 32'h0);
    chk("t4_alu_a",      aluif.a,        32'h7FFFFFFF);
    @(negedge CLK); rsp_ready = 2'b10; #1;
    chk("t4_valid1", 32'(rsp_valid), 32'h2);
    @(negedge CLK); rsp_ready = 2'b00;

    // Reset while in EXEC discards the op and returns ptr to 0.
    drive(0, ALU_ADD, 32'd9, 32'd9); req = 2'b01; #1;
    chk("t5_gnt0", 32'(gnt), 32'h1);
    @(negedge CLK); req = 2'b10; RST = 1'b1; #1;
    chk("t5_rst_gnt", 32'(gnt), 32'h0);
    @(negedge CLK); RST = 1'b0; req = 2'b00; #1;
    chk("t5_valid_after_rst", 32'(rsp_valid), 32'h0);
    chk("t5_out_after_rst",   rsp_out,        32'h0);
    chk("t5_alu_a_after_rst", aluif.a,        32'h0);
    @(negedge CLK); drive(0, ALU_ADD, 32'd2, 32'd2); drive(1, ALU_ADD, 32'd4, 32'hFFFFFFFF); req = 2'b11; #1;
    chk("t5_ptr_reset_gnt", 32'(gnt), 32'h1);
    push(2'b01, 32'd4, 3'b000);
    @(negedge CLK); req = 2'b10; #1;
    chk("t5_exec_gnt", 32'(gnt), 32'h0);
    @(negedge CLK); rsp_ready = 2'b01; #1;
    chk("t5_gnt1", 32'(gnt), 32'h2);
    push(2'b10, 32'd3, 3'b000);
    @(negedge CLK); req = 2'b00; rsp_ready = 2'b00; #1;
    chk("t5_exec2_valid", 32'(rsp_valid), 32'h0);
    @(negedge CLK); rsp_ready = 2'b10; #1;
    chk("t5_valid1", 32'(rsp_valid), 32'h2);
    @(negedge CLK); rsp_ready = 2'b00;
    @(negedge CLK); #3;
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
